// File: rtl/rat_pkg.sv
// Shared types and width helpers for the register alias table slice.
package rat_pkg;

    localparam int unsigned RAT_TAG_W = 5;

    // One alias-table entry: ROB tag plus "value in flight" flag.
    typedef struct packed {
        logic                 busy;
        logic [RAT_TAG_W-1:0] tag;
    } map_entry_t;

    // Index width for a table of n entries, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned arch_aw(input int unsigned num_arch);
        return idx_width(num_arch);
    endfunction

    function automatic int unsigned ckpt_cw(input int unsigned num_ckpt);
        return idx_width(num_ckpt);
    endfunction

endpackage

// File: rtl/rat_ckpt_bank.sv
// Checkpoint snapshot storage: NUM_CKPT copies of the alias table, each kept
// current with tag-matched commit clears, with one write and one read port.
module rat_ckpt_bank
    import rat_pkg::*;
#(
    parameter int unsigned NUM_ARCH = 32,
    parameter int unsigned TAG_W    = RAT_TAG_W,
    parameter int unsigned CMT_W    = 2,
    parameter int unsigned NUM_CKPT = 4,
    localparam int unsigned AW      = arch_aw(NUM_ARCH),
    localparam int unsigned CW      = ckpt_cw(NUM_CKPT)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_CKPT-1:0]              slot_valid,
    input  logic [CMT_W-1:0]                 cmt_valid,
    input  logic [CMT_W*AW-1:0]              cmt_dst,
    input  logic [CMT_W*TAG_W-1:0]           cmt_tag,
    input  logic                             wr_en,
    input  logic [CW-1:0]                    wr_slot,
    input  logic [NUM_ARCH-1:0][TAG_W-1:0]   wr_map,
    input  logic [NUM_ARCH-1:0]              wr_busy,
    input  logic [CW-1:0]                    rd_slot,
    output logic [NUM_ARCH-1:0][TAG_W-1:0]   rd_map,
    output logic [NUM_ARCH-1:0]              rd_busy
);

    logic [NUM_CKPT-1:0][NUM_ARCH-1:0][TAG_W-1:0] snap_map_q, snap_map_n;
    logic [NUM_CKPT-1:0][NUM_ARCH-1:0]            snap_busy_q, snap_busy_n;

    // Restore port reads the stored snapshot; the top applies commits on top.
    assign rd_map  = snap_map_q[rd_slot];
    assign rd_busy = snap_busy_q[rd_slot];

    // Next snapshot contents: commit clears on live slots, then the new take.
    always_comb begin
        logic [AW-1:0]    d;
        logic [TAG_W-1:0] t;
        snap_map_n  = snap_map_q;
        snap_busy_n = snap_busy_q;
        d = '0;
        t = '0;
        for (int unsigned s = 0; s < NUM_CKPT; s++) begin
            if (slot_valid[s]) begin
                for (int unsigned c = 0; c < CMT_W; c++) begin
                    if (cmt_valid[c]) begin
                        d = cmt_dst[c*AW +: AW];
                        t = cmt_tag[c*TAG_W +: TAG_W];
                        if (snap_busy_n[s][d] && (snap_map_n[s][d] == t)) begin
                            snap_busy_n[s][d] = 1'b0;
                            snap_map_n[s][d]  = TAG_W'(d);
                        end
                    end
                end
            end
        end
        // The incoming snapshot already has this cycle's commits folded in.
        if (wr_en) begin
            snap_map_n[wr_slot]  = wr_map;
            snap_busy_n[wr_slot] = wr_busy;
        end
    end

    // Snapshot registers, reset to the identity table.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned s = 0; s < NUM_CKPT; s++) begin
                for (int unsigned i = 0; i < NUM_ARCH; i++) begin
                    snap_map_q[s][i] <= TAG_W'(i);
                end
            end
            snap_busy_q <= '0;
        end else begin
            snap_map_q  <= snap_map_n;
            snap_busy_q <= snap_busy_n;
        end
    end

endmodule

// File: rtl/rat_multiport.sv
// Multi-port register alias table: DISP_W rename lanes with intra-group
// bypass, CMT_W tag-matched commit lanes, and checkpoint/flush recovery.
module rat_multiport
    import rat_pkg::*;
#(
    parameter int unsigned NUM_ARCH = 32,
    parameter int unsigned TAG_W    = RAT_TAG_W,
    parameter int unsigned DISP_W   = 2,
    parameter int unsigned CMT_W    = 2,
    parameter int unsigned NUM_CKPT = 4,
    localparam int unsigned AW      = arch_aw(NUM_ARCH),
    localparam int unsigned CW      = ckpt_cw(NUM_CKPT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DISP_W-1:0]       ren_valid,
    input  logic [DISP_W*AW-1:0]    ren_rs,
    input  logic [DISP_W*AW-1:0]    ren_rt,
    input  logic [DISP_W-1:0]       ren_wr,
    input  logic [DISP_W*AW-1:0]    ren_dst,
    input  logic [DISP_W*TAG_W-1:0] ren_tag,
    output logic [DISP_W*TAG_W-1:0] rs_tag,
    output logic [DISP_W*TAG_W-1:0] rt_tag,
    output logic [DISP_W-1:0]       rs_busy,
    output logic [DISP_W-1:0]       rt_busy,
    input  logic [CMT_W-1:0]        cmt_valid,
    input  logic [CMT_W*AW-1:0]     cmt_dst,
    input  logic [CMT_W*TAG_W-1:0]  cmt_tag,
    input  logic                    ckpt_take,
    output logic [CW-1:0]           ckpt_id,
    output logic                    ckpt_full,
    input  logic                    ckpt_release,
    input  logic                    flush,
    input  logic [CW-1:0]           flush_id,
    input  logic                    flush_all
);

    localparam logic [CW:0] FULL_CNT = (CW+1)'(NUM_CKPT);

    logic [NUM_ARCH-1:0][TAG_W-1:0] map_q, map_n;
    logic [NUM_ARCH-1:0]            busy_q, busy_n;
    logic [NUM_ARCH-1:0][TAG_W-1:0] bank_rd_map;
    logic [NUM_ARCH-1:0]            bank_rd_busy;
    logic [NUM_CKPT-1:0]            slot_valid;

    logic [CW-1:0] head_q, head_n, tail_q, tail_n;
    logic [CW:0]   count_q, count_n;
    logic          release_ok, take_ok;

    logic [DISP_W*TAG_W-1:0] rs_tag_n, rt_tag_n;
    logic [DISP_W-1:0]       rs_busy_n, rt_busy_n;

    function automatic logic [CW-1:0] ptr_inc(input logic [CW-1:0] p);
        return (p == CW'(NUM_CKPT-1)) ? '0 : p + 1'b1;
    endfunction

    // Distance from b forward to a, modulo NUM_CKPT.
    function automatic logic [CW:0] ptr_dist(input logic [CW-1:0] a, input logic [CW-1:0] b);
        return (a >= b) ? ({1'b0, a} - {1'b0, b})
                        : ({1'b0, a} + FULL_CNT - {1'b0, b});
    endfunction

    assign ckpt_id   = tail_q;
    assign ckpt_full = (count_q == FULL_CNT);

    // Pointer and occupancy bookkeeping; release is applied before take so a
    // full queue can accept a take in the same cycle it frees a slot.
    always_comb begin
        release_ok = ckpt_release && (count_q != '0);
        take_ok    = ckpt_take && !flush && !flush_all && (!ckpt_full || release_ok);
        head_n     = head_q;
        tail_n     = tail_q;
        count_n    = count_q;
        if (flush_all) begin
            head_n  = tail_q;
            count_n = '0;
        end else if (flush) begin
            tail_n  = ptr_inc(flush_id);
            head_n  = release_ok ? ptr_inc(head_q) : head_q;
            count_n = ptr_dist(flush_id, head_q) + 1'b1 - {{CW{1'b0}}, release_ok};
        end else begin
            if (take_ok)    tail_n = ptr_inc(tail_q);
            if (release_ok) head_n = ptr_inc(head_q);
            count_n = count_q + {{CW{1'b0}}, take_ok} - {{CW{1'b0}}, release_ok};
        end
        for (int unsigned s = 0; s < NUM_CKPT; s++) begin
            slot_valid[s] = (ptr_dist(CW'(s), head_q) < count_q);
        end
    end

    // Live table next state: restore, then commits, then renames, then squash.
    always_comb begin
        logic [AW-1:0]    d;
        logic [TAG_W-1:0] t;
        map_n  = map_q;
        busy_n = busy_q;
        d = '0;
        t = '0;
        if (flush) begin
            map_n  = bank_rd_map;
            busy_n = bank_rd_busy;
        end
        for (int unsigned c = 0; c < CMT_W; c++) begin
            if (cmt_valid[c]) begin
                d = cmt_dst[c*AW +: AW];
                t = cmt_tag[c*TAG_W +: TAG_W];
                if (busy_n[d] && (map_n[d] == t)) begin
                    busy_n[d] = 1'b0;
                    map_n[d]  = TAG_W'(d);
                end
            end
        end
        if (!flush) begin
            for (int unsigned l = 0; l < DISP_W; l++) begin
                if (ren_valid[l] && ren_wr[l]) begin
                    d = ren_dst[l*AW +: AW];
                    if (d != '0) begin
                        map_n[d]  = ren_tag[l*TAG_W +: TAG_W];
                        busy_n[d] = 1'b1;
                    end
                end
            end
        end
        if (flush_all) begin
            for (int unsigned i = 0; i < NUM_ARCH; i++) begin
                map_n[i] = TAG_W'(i);
            end
            busy_n = '0;
        end
    end

    // Source lookup per lane: older-lane bypass, then same-cycle commit, then table.
    always_comb begin
        logic [AW-1:0]    src;
        logic [TAG_W-1:0] hit_tag;
        logic             hit_busy;
        rs_tag_n  = '0;
        rt_tag_n  = '0;
        rs_busy_n = '0;
        rt_busy_n = '0;
        src       = '0;
        hit_tag   = '0;
        hit_busy  = 1'b0;
        for (int unsigned j = 0; j < DISP_W; j++) begin
            for (int unsigned k = 0; k < 2; k++) begin
                src      = (k == 0) ? ren_rs[j*AW +: AW] : ren_rt[j*AW +: AW];
                hit_tag  = map_q[src];
                hit_busy = busy_q[src];
                for (int unsigned c = 0; c < CMT_W; c++) begin
                    if (cmt_valid[c] && (cmt_dst[c*AW +: AW] == src) && busy_q[src] &&
                        (map_q[src] == cmt_tag[c*TAG_W +: TAG_W])) begin
                        hit_tag  = TAG_W'(src);
                        hit_busy = 1'b0;
                    end
                end
                // Ascending scan so the youngest older lane wins.
                for (int unsigned i = 0; i < j; i++) begin
                    if (ren_valid[i] && ren_wr[i] && (ren_dst[i*AW +: AW] == src)) begin
                        hit_tag  = ren_tag[i*TAG_W +: TAG_W];
                        hit_busy = 1'b1;
                    end
                end
                if ((src == '0) || !ren_valid[j]) begin
                    hit_tag  = '0;
                    hit_busy = 1'b0;
                end
                if (k == 0) begin
                    rs_tag_n[j*TAG_W +: TAG_W] = hit_tag;
                    rs_busy_n[j]               = hit_busy;
                end else begin
                    rt_tag_n[j*TAG_W +: TAG_W] = hit_tag;
                    rt_busy_n[j]               = hit_busy;
                end
            end
        end
    end

    // Live table, checkpoint pointers and registered lookup outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_ARCH; i++) begin
                map_q[i] <= TAG_W'(i);
            end
            busy_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            rs_tag  <= '0;
            rt_tag  <= '0;
            rs_busy <= '0;
            rt_busy <= '0;
        end else begin
            map_q   <= map_n;
            busy_q  <= busy_n;
            head_q  <= head_n;
            tail_q  <= tail_n;
            count_q <= count_n;
            rs_tag  <= rs_tag_n;
            rt_tag  <= rt_tag_n;
            rs_busy <= rs_busy_n;
            rt_busy <= rt_busy_n;
        end
    end

    rat_ckpt_bank #(
        .NUM_ARCH (NUM_ARCH),
        .TAG_W    (TAG_W),
        .CMT_W    (CMT_W),
        .NUM_CKPT (NUM_CKPT)
    ) u_bank (
        .clk        (clk),
        .rst        (rst),
        .slot_valid (slot_valid),
        .cmt_valid  (cmt_valid),
        .cmt_dst    (cmt_dst),
        .cmt_tag    (cmt_tag),
        .wr_en      (take_ok),
        .wr_slot    (tail_q),
        .wr_map     (map_n),
        .wr_busy    (busy_n),
        .rd_slot    (flush_id),
        .rd_map     (bank_rd_map),
        .rd_busy    (bank_rd_busy)
    );

endmodule

// File: tb/tb_rat_multiport.sv
// Directed bench for rat_multiport: a table of single-cycle lookup vectors
// followed by hand-written checkpoint, flush and reset sequences.
module tb_rat_multiport;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ren_valid;
    logic [9:0]  ren_rs, ren_rt, ren_dst, ren_tag;
    logic [1:0]  ren_wr;
    logic [9:0]  rs_tag, rt_tag;
    logic [1:0]  rs_busy, rt_busy;
    logic [1:0]  cmt_valid;
    logic [9:0]  cmt_dst, cmt_tag;
    logic        ckpt_take, ckpt_full, ckpt_release, flush, flush_all;
    logic [1:0]  ckpt_id, flush_id;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rat_multiport #(
        .NUM_ARCH (32),
        .TAG_W    (5),
        .DISP_W   (2),
        .CMT_W    (2),
        .NUM_CKPT (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ren_valid    (ren_valid),
        .ren_rs       (ren_rs),
        .ren_rt       (ren_rt),
        .ren_wr       (ren_wr),
        .ren_dst      (ren_dst),
        .ren_tag      (ren_tag),
        .rs_tag       (rs_tag),
        .rt_tag       (rt_tag),
        .rs_busy      (rs_busy),
        .rt_busy      (rt_busy),
        .cmt_valid    (cmt_valid),
        .cmt_dst      (cmt_dst),
        .cmt_tag      (cmt_tag),
        .ckpt_take    (ckpt_take),
        .ckpt_id      (ckpt_id),
        .ckpt_full    (ckpt_full),
        .ckpt_release (ckpt_release),
        .flush        (flush),
        .flush_id     (flush_id),
        .flush_all    (flush_all)
    );

    typedef struct {
        string      name;
        logic [1:0] rv;
        logic [4:0] rs0, rt0, rs1, rt1;
        logic [1:0] wr;
        logic [4:0] d0, t0, d1, t1;
        logic [1:0] cv;
        logic [4:0] cd0, ct0, cd1, ct1;
        logic [4:0] ers0, ert0, ers1, ert1;
        logic [1:0] ebs, ebt;
    } vec_t;

    vec_t vt[12];

    task automatic idle();
        ren_valid    = '0;
        ren_rs       = '0;
        ren_rt       = '0;
        ren_wr       = '0;
        ren_dst      = '0;
        ren_tag      = '0;
        cmt_valid    = '0;
        cmt_dst      = '0;
        cmt_tag      = '0;
        ckpt_take    = 1'b0;
        ckpt_release = 1'b0;
        flush        = 1'b0;
        flush_id     = '0;
        flush_all    = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic lanes(input logic [1:0] rv, input logic [4:0] a0, input logic [4:0] b0,
                         input logic [4:0] a1, input logic [4:0] b1);
        ren_valid = rv;
        ren_rs    = {a1, a0};
        ren_rt    = {b1, b0};
    endtask

    task automatic chk_look(input string nm, input logic [4:0] ers0, input logic [4:0] ert0,
                            input logic [4:0] ers1, input logic [4:0] ert1,
                            input logic [1:0] ebs, input logic [1:0] ebt);
        check(nm, {8'd0, rs_tag, rt_tag, rs_busy, rt_busy},
                  {8'd0, ers1, ers0, ert1, ert0, ebs, ebt});
    endtask

    task automatic chk_ckpt(input string nm, input logic full, input logic [1:0] id);
        check(nm, {29'd0, ckpt_full, ckpt_id}, {29'd0, full, id});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst = 1'b0;
        //          name                rv     rs0 rt0 rs1 rt1 wr     d0 t0  d1 t1  cv     cd0 ct0 cd1 ct1 ers0 ert0 ers1 ert1 ebs    ebt
        vt[0]  = '{"reset_lookup",      2'b01, 5,  0,  0,  0,  2'b00, 0, 0,  0, 0,  2'b00, 0,  0,  0,  0,  5,   0,   0,   0,   2'b00, 2'b00};
        vt[1]  = '{"bypass_r3",         2'b11, 1,  2,  3,  4,  2'b01, 3, 7,  0, 0,  2'b00, 0,  0,  0,  0,  1,   2,   7,   4,   2'b10, 2'b00};
        vt[2]  = '{"map_r3",            2'b11, 3,  0,  4,  3,  2'b10, 0, 0,  4, 2,  2'b00, 0,  0,  0,  0,  7,   0,   4,   7,   2'b01, 2'b10};
        vt[3]  = '{"bypass_r4",         2'b11, 4,  3,  4,  6,  2'b01, 4, 9,  0, 0,  2'b00, 0,  0,  0,  0,  2,   7,   9,   6,   2'b11, 2'b01};
        vt[4]  = '{"stale_commit",      2'b01, 4,  0,  0,  0,  2'b00, 0, 0,  0, 0,  2'b01, 4,  2,  0,  0,  9,   0,   0,   0,   2'b01, 2'b00};
        vt[5]  = '{"commit_bypass",     2'b01, 4,  3,  0,  0,  2'b00, 0, 0,  0, 0,  2'b01, 4,  9,  0,  0,  4,   7,   0,   0,   2'b00, 2'b01};
        vt[6]  = '{"commit_lane1",      2'b01, 4,  3,  0,  0,  2'b00, 0, 0,  0, 0,  2'b10, 0,  0,  3,  7,  4,   3,   0,   0,   2'b00, 2'b00};
        vt[7]  = '{"dual_write",        2'b11, 3,  0,  8,  0,  2'b11, 8, 10, 8, 11, 2'b00, 0,  0,  0,  0,  3,   0,   10,  0,   2'b10, 2'b00};
        vt[8]  = '{"high_lane_wins",    2'b11, 8,  0,  0,  8,  2'b01, 0, 12, 0, 0,  2'b00, 0,  0,  0,  0,  11,  0,   0,   11,  2'b01, 2'b10};
        vt[9]  = '{"rename_vs_commit",  2'b11, 8,  0,  8,  0,  2'b01, 8, 13, 0, 0,  2'b01, 8,  11, 0,  0,  8,   0,   13,  0,   2'b10, 2'b00};
        vt[10] = '{"rename_wins",       2'b01, 8,  4,  0,  0,  2'b00, 0, 0,  0, 0,  2'b00, 0,  0,  0,  0,  13,  4,   0,   0,   2'b01, 2'b00};
        vt[11] = '{"idle_lane_zero",    2'b10, 8,  8,  8,  5,  2'b00, 0, 0,  0, 0,  2'b00, 0,  0,  0,  0,  0,   0,   13,  5,   2'b10, 2'b00};

        #12 rst = 1'b1;
        tick();
        chk_look("reset_outputs", 0, 0, 0, 0, 2'b00, 2'b00);
        chk_ckpt("reset_ckpt", 1'b0, 2'd0);

        for (int i = 0; i < 12; i++) begin
            ren_valid = vt[i].rv;
            ren_rs    = {vt[i].rs1, vt[i].rs0};
            ren_rt    = {vt[i].rt1, vt[i].rt0};
            ren_wr    = vt[i].wr;
            ren_dst   = {vt[i].d1, vt[i].d0};
            ren_tag   = {vt[i].t1, vt[i].t0};
            cmt_valid = vt[i].cv;
            cmt_dst   = {vt[i].cd1, vt[i].cd0};
            cmt_tag   = {vt[i].ct1, vt[i].ct0};
            tick();
            chk_look(vt[i].name, vt[i].ers0, vt[i].ert0, vt[i].ers1, vt[i].ert1, vt[i].ebs, vt[i].ebt);
        end
        idle();

        // Checkpoint, rename past it, commit the checkpointed tag, restore.
        ren_valid = 2'b01; ren_wr = 2'b01; ren_dst = {5'd0, 5'd6}; ren_tag = {5'd0, 5'd1};
        tick(); idle();
        chk_ckpt("take_uses_slot0", 1'b0, 2'd0);
        ckpt_take = 1'b1;
        tick(); idle();
        chk_ckpt("after_take", 1'b0, 2'd1);
        ren_valid = 2'b01; ren_wr = 2'b01; ren_dst = {5'd0, 5'd6}; ren_tag = {5'd0, 5'd5};
        tick(); idle();
        cmt_valid = 2'b01; cmt_dst = {5'd0, 5'd6}; cmt_tag = {5'd0, 5'd1};
        tick(); idle();
        flush = 1'b1; flush_id = 2'd0;
        tick(); idle();
        chk_ckpt("flush_ptr", 1'b0, 2'd1);
        lanes(2'b11, 6, 8, 3, 0);
        tick(); idle();
        chk_look("flush_restore", 6, 13, 3, 0, 2'b00, 2'b01);

        // Fill the checkpoint queue from a fresh reset.
        rst = 1'b0;
        #3 rst = 1'b1;
        lanes(2'b01, 8, 0, 0, 0);
        tick(); idle();
        chk_look("reset_identity", 8, 0, 0, 0, 2'b00, 2'b00);
        ckpt_take = 1'b1;
        tick(); tick(); tick();
        chk_ckpt("three_takes", 1'b0, 2'd3);
        tick();
        chk_ckpt("four_takes_full", 1'b1, 2'd0);
        tick();
        chk_ckpt("take_when_full", 1'b1, 2'd0);
        ckpt_release = 1'b1;
        tick(); idle();
        chk_ckpt("release_take_full", 1'b1, 2'd1);
        flush = 1'b1; flush_id = 2'd2; ckpt_release = 1'b1;
        tick(); idle();
        chk_ckpt("flush_release", 1'b0, 2'd3);

        // Full squash overrides renames and takes; checkpoint queue empties.
        ren_valid = 2'b11; ren_wr = 2'b11; ren_dst = {5'd10, 5'd9}; ren_tag = {5'd4, 5'd3};
        tick(); idle();
        ren_valid = 2'b11; ren_wr = 2'b11; ren_dst = {5'd9, 5'd11}; ren_tag = {5'd8, 5'd6};
        ckpt_take = 1'b1; flush_all = 1'b1;
        tick(); idle();
        chk_ckpt("flush_all_ptr", 1'b0, 2'd3);
        lanes(2'b11, 9, 10, 11, 0);
        tick(); idle();
        chk_look("flush_all_identity", 9, 10, 11, 0, 2'b00, 2'b00);
        ckpt_take = 1'b1;
        tick(); tick(); tick(); idle();
        chk_ckpt("count_cleared", 1'b0, 2'd2);

        // Asynchronous reset arriving mid-cycle while a flush is requested.
        ren_valid = 2'b01; ren_wr = 2'b01; ren_dst = {5'd0, 5'd12}; ren_tag = {5'd0, 5'd6};
        ren_rs = {5'd0, 5'd5};
        tick(); idle();
        flush = 1'b1; flush_id = 2'd0;
        #2 rst = 1'b0; flush = 1'b0;
        #1 check("async_reset", {5'd0, rs_tag, rt_tag, rs_busy, rt_busy, ckpt_full, ckpt_id}, 32'd0);
        #2 rst = 1'b1;
        lanes(2'b01, 12, 6, 0, 0);
        tick(); idle();
        chk_look("post_reset_identity", 12, 6, 0, 0, 2'b00, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
